memio_arbiter: RTL

//  Shares the SoC device bus (12b address, 16b data) between two bus masters: M0 = cpu, M1 = SPI boot loader / debug master.

---
 rtl/memio_pkg.sv | 31 +++
 rtl/memio_decode.sv | 20 ++
 rtl/memio_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/memio_pkg.sv
// Shared types and constants for the device-bus arbiter: FSM states, decode
// regions, address bit positions and reset values.
package memio_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_WAIT,
      ST_RESP
   } state_t;

   typedef enum logic [1:0] {
      REG_BOOT,
      REG_TIMER,
      REG_SPI
   } region_t;

   // addr[11:6] != 0 selects spi; below that, addr[5] splits timer from bootrom
   localparam int DEC_LSB = 5;
   localparam int SPI_LSB = 6;

   localparam logic    PTR_RST    = 1'b0;
   localparam region_t REGION_RST = REG_BOOT;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/memio_decode.sv
// Address-to-region decode for the device bus; fed only with the address bits
// that take part in the decode.
module memio_decode
   import memio_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic [ADDR_W-1-DEC_LSB:0] dec_bits,
   output region_t                   region
);

   always_comb begin
      region = REG_BOOT;
      if (dec_bits[ADDR_W-1-DEC_LSB:SPI_LSB-DEC_LSB] != '0)
         region = REG_SPI;
      else if (dec_bits[0])
         region = REG_TIMER;
   end

endmodule

// File: rtl/memio_arbiter.sv
// Two-master round-robin arbiter for the spi / timer / bootrom device bus,
// one transaction outstanding, per-region wait states and registered read return.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; arbitrate and latch the winner at the edge
// ADDR    | gnt and one cs_* pulse; wait counter holds the region wait
// WAIT    | slave access in progress; counter decrements to 1
// RESP    | ack to the owner; m_rdata valid for reads
module memio_arbiter
   import memio_pkg::*;
#(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 16,
   parameter int BOOT_WAIT  = 1,
   parameter int SPI_WAIT   = 2,
   parameter int TIMER_WAIT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m0_req,
   input  logic              m0_rdwr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_ack,
   input  logic              m1_req,
   input  logic              m1_rdwr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m_rdata,
   output logic [ADDR_W-1:0] dev_addr,
   output logic [DATA_W-1:0] dev_wdata,
   output logic              dev_rdwr,
   output logic              cs_spi,
   output logic              cs_timer,
   output logic              cs_boot,
   input  logic [7:0]        spi_rdata,
   input  logic [DATA_W-1:0] boot_rdata
);

   localparam int MAX_WAIT = max3(BOOT_WAIT, SPI_WAIT, TIMER_WAIT);
   localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   state_t            state;
   region_t           region;
   region_t           win_region;
   logic [CNT_W-1:0]  cnt;
   logic              owner_m1;
   logic              last_m1;
   logic              win_m1;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              win_rdwr;
   logic [DATA_W-1:0] rd_mux;
   logic              done;

   function automatic logic [CNT_W-1:0] region_wait(input region_t r);
      case (r)
         REG_SPI:   return CNT_W'(SPI_WAIT);
         REG_TIMER: return CNT_W'(TIMER_WAIT);
         default:   return CNT_W'(BOOT_WAIT);
      endcase
   endfunction

   // On a tie the master not granted last wins
   always_comb begin
      win_m1 = m1_req;
      if (m0_req && m1_req)
         win_m1 = ~last_m1;
      win_addr  = win_m1 ? m1_addr  : m0_addr;
      win_wdata = win_m1 ? m1_wdata : m0_wdata;
      win_rdwr  = win_m1 ? m1_rdwr  : m0_rdwr;
   end

   memio_decode #(.ADDR_W(ADDR_W)) u_decode (
      .dec_bits (win_addr[ADDR_W-1:DEC_LSB]),
      .region   (win_region)
   );

   always_comb begin
      case (region)
         REG_SPI:  rd_mux = DATA_W'(spi_rdata);
         REG_BOOT: rd_mux = boot_rdata;
         default:  rd_mux = '0;
      endcase
   end

   assign done = ((state == ST_ADDR) && (cnt == '0)) ||
                 ((state == ST_WAIT) && (cnt == CNT_W'(1)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         region    <= REGION_RST;
         cnt       <= '0;
         owner_m1  <= 1'b0;
         last_m1   <= PTR_RST;
         dev_addr  <= '0;
         dev_wdata <= '0;
         dev_rdwr  <= 1'b0;
         m_rdata   <= '0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         cs_spi    <= 1'b0;
         cs_timer  <= 1'b0;
         cs_boot   <= 1'b0;
      end else begin
         m0_gnt   <= 1'b0;
         m1_gnt   <= 1'b0;
         m0_ack   <= 1'b0;
         m1_ack   <= 1'b0;
         cs_spi   <= 1'b0;
         cs_timer <= 1'b0;
         cs_boot  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (m0_req || m1_req) begin
                  owner_m1  <= win_m1;
                  last_m1   <= win_m1;
                  dev_addr  <= win_addr;
                  dev_wdata <= win_wdata;
                  dev_rdwr  <= win_rdwr;
                  region    <= win_region;
                  cnt       <= region_wait(win_region);
                  m0_gnt    <= ~win_m1;
                  m1_gnt    <= win_m1;
                  cs_spi    <= (win_region == REG_SPI);
                  cs_timer  <= (win_region == REG_TIMER);
                  cs_boot   <= (win_region == REG_BOOT);
                  state     <= ST_ADDR;
               end
            end
            ST_ADDR: if (!done) state <= ST_WAIT;
            ST_WAIT: if (!done) cnt <= cnt - CNT_W'(1);
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
         if (done) begin
            state  <= ST_RESP;
            m0_ack <= ~owner_m1;
            m1_ack <= owner_m1;
            if (!dev_rdwr)
               m_rdata <= rd_mux;
         end
      end
   end

endmodule
